scratchpad_stream_reader: RTL

SCRATCHPAD_STREAM_READER -- requirements
Module: scratchpad_stream_reader

---
 rtl/scratchpad_stream_reader.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/scratchpad_stream_reader.sv
// scratchpad_stream_reader
//   Reads a burst of words from a scratchpad and presents them as a
//   valid/ready stream. The word address starts at base_addr and advances
//   by stride modulo DEPTH.
//
// State table:
//   IDLE  | waiting for start; captures base/stride/count
//   READ  | issuing addresses and filling the output register
//   FLUSH | last word loaded, waiting for it to be accepted
//   DONE  | single-cycle completion, done=1
//
// Ports:
//   clk, rst (async, active-low)
//   start, abort                   burst control
//   base_addr, stride, count       burst parameters, captured on start
//   sp_raddr / sp_dout             scratchpad read port (combinational data)
//   out_data/out_valid/out_ready/out_last  output stream
//   busy, done                     status
module scratchpad_stream_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] stride,
    input  logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] sp_raddr,
    input  logic [DATA_WIDTH-1:0] sp_dout,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH+1)'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [ADDR_WIDTH:0]   remain_q, remain_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic                  a_vld_q, a_vld_d;
    logic                  a_last_q, a_last_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  advance;
    logic [ADDR_WIDTH:0]   sum_w;
    logic [ADDR_WIDTH:0]   wrap_w;

    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        stride_d    = stride_q;
        remain_d    = remain_q;
        raddr_d     = raddr_q;
        a_vld_d     = a_vld_q;
        a_last_d    = a_last_q;
        data_d      = data_q;
        valid_d     = valid_q;
        last_d      = last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        // The address register (sp_raddr) and the output register form a
        // two-stage pipe; both move only when the output slot is free.
        advance = !valid_q || out_ready;
        sum_w   = {1'b0, next_addr_q} + {1'b0, stride_q};
        wrap_w  = (sum_w >= DEPTH_W) ? (sum_w - DEPTH_W) : sum_w;

        unique case (state_q)
            IDLE: begin
                busy_d  = 1'b0;
                a_vld_d = 1'b0;
                if (start && !abort) begin
                    next_addr_d = base_addr;
                    stride_d    = stride;
                    remain_d    = count;
                    if (count == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = READ;
                        busy_d  = 1'b1;
                    end
                end
            end
            READ, FLUSH: begin
                if (abort) begin
                    state_d  = IDLE;
                    valid_d  = 1'b0;
                    last_d   = 1'b0;
                    busy_d   = 1'b0;
                    a_vld_d  = 1'b0;
                    a_last_d = 1'b0;
                    remain_d = '0;
                end else if (state_q == FLUSH) begin
                    if (valid_q && out_ready) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else if (advance) begin
                    valid_d = a_vld_q;
                    last_d  = a_vld_q && a_last_q;
                    if (a_vld_q) begin
                        data_d = sp_dout;
                    end
                    if (a_vld_q && a_last_q) begin
                        state_d  = FLUSH;
                        a_vld_d  = 1'b0;
                        a_last_d = 1'b0;
                    end else if (remain_q != '0) begin
                        raddr_d     = next_addr_q;
                        a_vld_d     = 1'b1;
                        a_last_d    = (remain_q == ONE_W);
                        next_addr_d = wrap_w[ADDR_WIDTH-1:0];
                        remain_d    = remain_q - ONE_W;
                    end else begin
                        a_vld_d = 1'b0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            next_addr_q <= '0;
            stride_q    <= '0;
            remain_q    <= '0;
            raddr_q     <= '0;
            a_vld_q     <= 1'b0;
            a_last_q    <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            stride_q    <= stride_d;
            remain_q    <= remain_d;
            raddr_q     <= raddr_d;
            a_vld_q     <= a_vld_d;
            a_last_q    <= a_last_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign sp_raddr  = raddr_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
